instr_fetch_issue: RTL and testbench
====================================

// Module: instr_fetch_issue
// PURPOSE
//   Upstream neighbour of the ALU stage: holds the PC, fetches 32-bit words from a
//   synchronous instruction memory, and issues each word to the ALU as a stable
//   `instruction` bus qualified by a one-cycle `alu` strobe (the ALU samples on posedge alu).
//   Supports stall, PC redirect (branch/jump), and halt on a sentinel instruction word.
// PARAMETERS
//   PC_W       10             PC / imem word-address width; PC counts words, not bytes
//   RESET_PC   0              PC loaded on reset and on start
//   HALT_WORD  32'hFFFF_FFFF  fetched word that stops the stage; it is never issued
// PORTS
//   clk            in   1     single clock, all state on posedge
//   rst            in   1     synchronous, active-high reset
//   start          in   1     leave IDLE and begin fetching at RESET_PC
//   stall          in   1     downstream not ready; holds the stage in ISSUE
//   redirect_valid in   1     load redirect_pc and restart fetch
//   redirect_pc    in   PC_W  redirect target (word address)
//   imem_en        out  1     read enable to instruction memory
//   imem_addr      out  PC_W  read address (= pc)
//   imem_rdata     in   32    read data, valid the cycle after imem_en
//   instruction    out  32    last issued word; held stable between issues
//   alu            out  1     one-cycle issue strobe to the ALU
//   pc_out         out  PC_W  PC of the word currently in instruction
//   halted         out  1     high while in HALT
//   issued_cnt     out  32    count of issued instructions, wraps at 2^32
// BEHAVIOUR
//   Reset values: pc=RESET_PC, state=IDLE, imem_en=0, instruction=0, alu=0, pc_out=0,
//     halted=0, issued_cnt=0. rst wins over every other input in every state, including mid-fetch.
//   All outputs are registered. imem_addr is pc. imem_en=1 only in FETCH.
//   FSM states: IDLE, FETCH, WAIT, ISSUE, HALT.
//     IDLE : start=1 -> pc<=RESET_PC, go to FETCH. redirect and stall are ignored.
//     FETCH: imem_en=1, addr=pc -> WAIT.
//     WAIT : capture imem_rdata into an internal buffer.
//            If the word equals HALT_WORD -> HALT; otherwise -> ISSUE.
//     ISSUE: stall=1 -> stay in ISSUE, alu stays 0.
//            stall=0 -> at the edge: instruction<=buffer, pc_out<=pc, alu<=1,
//            issued_cnt++, pc<=pc+1 (wraps modulo 2^PC_W), go to FETCH.
//     HALT : halted=1, alu=0. Exit only via rst; start and redirect are ignored.
//   alu is high for exactly one cycle, the FETCH cycle after the issue edge.
//     instruction changes only on an issue edge, so it is stable for the whole time alu is high.
//   Throughput: 1 instruction per 3 cycles with no stall. Latency from start to first alu=1 is 4 edges.
//   Redirect, valid in FETCH, WAIT or ISSUE:
//     pc<=redirect_pc and state<=FETCH. Any in-flight or buffered word is discarded, with no alu strobe.
//     Redirect has priority over stall and over issue in the same cycle.
//     instruction and pc_out keep their previous values.
//   A HALT_WORD seen in WAIT while redirect_valid=1 is discarded; the redirect wins.
//   issued_cnt does not count discarded words or HALT_WORD.
// TESTING
//   1. imem[0..2]={A,B,C}, imem[3]=HALT_WORD, start pulse -> alu pulses with instruction=A,B,C,
//      3 cycles apart; pc_out=0,1,2; then halted=1 and issued_cnt=3.
//   2. stall=1 for 5 cycles while in ISSUE holding B -> alu stays 0 and instruction keeps A;
//      B issues on the first cycle with stall=0; no word is lost or duplicated.
//   3. redirect_valid=1, redirect_pc=0x20 during WAIT for pc=1 -> that word is never issued;
//      next alu carries imem[0x20] with pc_out=0x20.
//   4. redirect_valid=1 and stall=1 in the same ISSUE cycle -> redirect taken,
//      FETCH at redirect_pc, no alu strobe.
//   5. PC wrap: PC_W=4, fill imem with 16 non-halt words -> after pc=15 issues, the next fetch is
//      addr 0; issued_cnt keeps incrementing.
//   6. rst=1 asserted in WAIT, then in HALT -> all outputs return to reset values next edge;
//      start restarts fetch at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_issue.sv
// instr_fetch_issue: holds the PC, reads 32-bit words from a synchronous
// instruction memory and issues them to the ALU stage.
//
// Handshake: a fetched word waits in ISSUE and transfers on the first edge
// where stall is low (stall acts as "downstream not ready"). The transfer is
// announced by alu, high for exactly the one cycle after the transfer edge.
// instruction and pc_out change only on a transfer edge, so they are stable
// while alu is high and hold until the next transfer.
module instr_fetch_issue #(
    parameter int unsigned     PC_W      = 10,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]     HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instruction,
    output logic            alu,
    output logic [PC_W-1:0] pc_out,
    output logic            halted,
    output logic [31:0]     issued_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [31:0]     buffer;

    // The read address is the PC register itself, so it is already registered.
    assign imem_addr = pc;

    // Fetch/issue sequencer; every output is updated here so all are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            buffer      <= '0;
            imem_en     <= 1'b0;
            instruction <= '0;
            alu         <= 1'b0;
            pc_out      <= '0;
            halted      <= 1'b0;
            issued_cnt  <= '0;
        end else begin
            // alu is a strobe: it only survives the cycle after an issue edge.
            alu <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc      <= RESET_PC;
                        state   <= S_FETCH;
                        imem_en <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (redirect_valid) begin
                        // The read launched this cycle is simply never captured.
                        pc      <= redirect_pc;
                        imem_en <= 1'b1;
                    end else begin
                        state   <= S_WAIT;
                        imem_en <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        // Redirect beats a halt word arriving in the same cycle.
                        pc      <= redirect_pc;
                        state   <= S_FETCH;
                        imem_en <= 1'b1;
                    end else if (imem_rdata == HALT_WORD) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        buffer <= imem_rdata;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (redirect_valid) begin
                        // Buffered word is dropped; no strobe, outputs keep old word.
                        pc      <= redirect_pc;
                        state   <= S_FETCH;
                        imem_en <= 1'b1;
                    end else if (!stall) begin
                        instruction <= buffer;
                        pc_out      <= pc;
                        alu         <= 1'b1;
                        issued_cnt  <= issued_cnt + 32'd1;
                        pc          <= pc + PC_W'(1);
                        state       <= S_FETCH;
                        imem_en     <= 1'b1;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    imem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Self-checking bench for instr_fetch_issue: directed scenarios plus random
// stall/redirect/start/reset traffic, checked every cycle against a
// word-level reference model and an issue scoreboard.
module tb_instr_fetch_issue;

  localparam int          PC_W      = 10;
  localparam int          DEPTH     = 1 << PC_W;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam int          W         = PC_W + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [PC_W-1:0] redirect_pc = '0;
  logic            imem_en;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata = '0;
  logic [31:0]     instruction;
  logic            alu;
  logic [PC_W-1:0] pc_out;
  logic            halted;
  logic [31:0]     issued_cnt;

  logic [31:0] mem [DEPTH];

  instr_fetch_issue #(.PC_W(PC_W), .RESET_PC('0), .HALT_WORD(HALT_WORD)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruction(instruction), .alu(alu), .pc_out(pc_out),
    .halted(halted), .issued_cnt(issued_cnt)
  );

  // synchronous instruction memory: data valid the cycle after the enable
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  // second instance with a 4-bit PC for the wrap-around scenario
  logic        rst2 = 1'b1;
  logic        start2 = 1'b0;
  logic        stall2 = 1'b0;
  logic        redirect_valid2 = 1'b0;
  logic [3:0]  redirect_pc2 = '0;
  logic        imem_en2;
  logic [3:0]  imem_addr2;
  logic [31:0] imem_rdata2 = '0;
  logic [31:0] instruction2;
  logic        alu2;
  logic [3:0]  pc_out2;
  logic        halted2;
  logic [31:0] issued_cnt2;
  logic [31:0] mem2 [16];

  instr_fetch_issue #(.PC_W(4), .RESET_PC(4'd0), .HALT_WORD(HALT_WORD)) dut_w (
    .clk(clk), .rst(rst2), .start(start2), .stall(stall2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .instruction(instruction2), .alu(alu2), .pc_out(pc_out2),
    .halted(halted2), .issued_cnt(issued_cnt2)
  );

  always @(posedge clk) if (imem_en2) imem_rdata2 <= mem2[imem_addr2];

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A running stage spends one cycle fetching, one waiting for data, then
  // offers the word until stall is low; a redirect restarts the fetch at the
  // new address and drops whatever word was in progress.
  bit              m_run   = 1'b0;
  bit              m_halt  = 1'b0;
  bit              m_alu   = 1'b0;
  int              m_age   = 0;
  logic [PC_W-1:0] m_pc    = '0;
  logic [PC_W-1:0] m_pcout = '0;
  logic [31:0]     m_instr = '0;
  logic [31:0]     m_cnt   = '0;
  logic [W-1:0]    exp_q[$];

  always @(posedge clk) begin
    m_alu = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_halt = 1'b0; m_age = 0; m_pc = '0;
      m_pcout = '0; m_instr = '0; m_cnt = '0;
    end else if (m_run) begin
      if (redirect_valid) begin
        m_pc = redirect_pc; m_age = 0;
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (m_age == 1) begin
        if (mem[m_pc] == HALT_WORD) begin
          m_run = 1'b0; m_halt = 1'b1;
        end else begin
          m_age = 2;
        end
      end else if (!stall) begin
        m_instr = mem[m_pc];
        m_pcout = m_pc;
        m_alu   = 1'b1;
        m_cnt   = m_cnt + 32'd1;
        exp_q.push_back({m_pc, m_instr});
        m_pc    = m_pc + 1'b1;
        m_age   = 0;
      end
    end else if (!m_halt && start) begin
      m_run = 1'b1; m_pc = '0; m_age = 0;
    end
  end

  // ---------------- per-cycle scoreboard ----------------
  bit           chk_en = 1'b0;
  logic [W-1:0] sb_e;

  always @(negedge clk) begin
    if (chk_en) begin
      check("alu", alu, m_alu);
      check("instruction", instruction, m_instr);
      check("pc_out", pc_out, m_pcout);
      check("halted", halted, m_halt);
      check("issued_cnt", issued_cnt, m_cnt);
      check("imem_en", imem_en, (m_run && m_age == 0));
      check("imem_addr", imem_addr, m_pc);
      if (alu) begin
        check("sb_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          sb_e = exp_q.pop_front();
          check("sb_issue", {pc_out, instruction}, sb_e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT_WORD) w = 32'h0;
    return w;
  endfunction

  // holds rst for one edge while the memory image is replaced
  task automatic reset_and_fill();
    rst = 1'b1; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_alu(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!alu && n < 16);
    check("alu_seen", alu, 1);
  endtask

  task automatic wait_halted();
    int n = 0;
    do begin @(negedge clk); n++; end while (!halted && n < 24);
    check("halt_seen", halted, 1);
  endtask

  task automatic wrap_test();
    int n;
    for (int i = 0; i < 16; i++) mem2[i] = 32'h5A00_0000 | i;
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!alu2 && n < 8);
      check("wrap_alu", alu2, 1);
      check("wrap_pc_out", pc_out2, k % 16);
      check("wrap_instr", instruction2, mem2[k % 16]);
      check("wrap_cnt", issued_cnt2, k + 1);
      if (k == 15) check("wrap_next_addr", {imem_en2, imem_addr2}, {1'b1, 4'd0});
    end
  endtask

  // ---------------- test sequence ----------------
  int          n;
  logic [31:0] wa, wb, wc, wd;

  initial begin
    reset_and_fill();
    @(negedge clk);
    chk_en = 1'b1;

    // reset values
    release_reset();
    check("rst_alu", alu, 0);
    check("rst_imem_en", imem_en, 0);
    check("rst_cnt", issued_cnt, 0);
    check("rst_instruction", instruction, 0);

    // 1: three words then a halt word
    reset_and_fill();
    wa = 32'h1111_0001; wb = 32'h2222_0002; wc = 32'h3333_0003;
    mem[0] = wa; mem[1] = wb; mem[2] = wc; mem[3] = HALT_WORD;
    release_reset();
    pulse_start();
    wait_alu(n);
    check("t1_latency", n + 1, 4);
    check("t1_a", {pc_out, instruction}, {10'd0, wa});
    wait_alu(n);
    check("t1_spacing_b", n, 3);
    check("t1_b", {pc_out, instruction}, {10'd1, wb});
    wait_alu(n);
    check("t1_spacing_c", n, 3);
    check("t1_c", {pc_out, instruction}, {10'd2, wc});
    wait_halted();
    check("t1_cnt", issued_cnt, 3);

    // 2: stall holds B in ISSUE for five cycles
    reset_and_fill();
    wa = mem[0]; wb = mem[1]; wc = mem[2]; wd = mem[3]; mem[4] = HALT_WORD;
    release_reset();
    pulse_start();
    wait_alu(n);
    stall = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("t2_stalled_alu", alu, 0);
      check("t2_stalled_instr", instruction, wa);
    end
    stall = 1'b0;
    @(negedge clk);
    check("t2_b_alu", alu, 1);
    check("t2_b", instruction, wb);
    wait_alu(n);
    check("t2_c", instruction, wc);
    wait_alu(n);
    check("t2_d", instruction, wd);
    wait_halted();
    check("t2_cnt", issued_cnt, 4);

    // 3: redirect during WAIT of pc=1
    reset_and_fill();
    wc = 32'hC0DE_0020; mem[32] = wc; mem[33] = HALT_WORD;
    release_reset();
    pulse_start();
    n = 0;
    do begin @(negedge clk); n++; end while (!(imem_en && imem_addr == 10'd1) && n < 16);
    check("t3_fetch_pc1", {imem_en, imem_addr}, {1'b1, 10'd1});
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 10'h20;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_alu(n);
    check("t3_target", {pc_out, instruction}, {10'h20, wc});
    wait_halted();
    check("t3_cnt", issued_cnt, 2);

    // 4: redirect and stall together in ISSUE
    reset_and_fill();
    wd = 32'hBEEF_0030; mem[48] = wd; mem[49] = HALT_WORD;
    release_reset();
    pulse_start();
    wait_alu(n);
    stall = 1'b1;
    repeat (4) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 10'h30;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0;
    check("t4_no_alu", alu, 0);
    check("t4_fetch", {imem_en, imem_addr}, {1'b1, 10'h30});
    wait_alu(n);
    check("t4_target", {pc_out, instruction}, {10'h30, wd});
    check("t4_cnt", issued_cnt, 2);

    // 6: reset in WAIT, then in HALT, then restart
    reset_and_fill();
    mem[3] = HALT_WORD;
    release_reset();
    pulse_start();
    wait_alu(n);
    wait_alu(n);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_wait_rst", {alu, imem_en, halted, issued_cnt, instruction, pc_out},
          {3'b000, 32'd0, 32'd0, 10'd0});
    rst = 1'b0;
    pulse_start();
    wait_halted();
    rst = 1'b1;
    @(negedge clk);
    check("t6_halt_rst", {alu, imem_en, halted, issued_cnt, instruction, pc_out, imem_addr},
          {3'b000, 32'd0, 32'd0, 10'd0, 10'd0});
    rst = 1'b0;
    pulse_start();
    wait_alu(n);
    check("t6_restart", {pc_out, instruction}, {10'd0, mem[0]});

    // 5: PC wrap on the 4-bit instance
    wrap_test();

    // random traffic
    for (int run = 0; run < 8; run++) begin
      reset_and_fill();
      for (int i = 0; i < DEPTH; i++) if ($urandom_range(0, 39) == 0) mem[i] = HALT_WORD;
      release_reset();
      pulse_start();
      for (int c = 0; c < 400; c++) begin
        stall          = ($urandom_range(0, 3) == 0);
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_pc    = PC_W'($urandom_range(0, DEPTH - 1));
        start          = ($urandom_range(0, 31) == 0);
        rst            = ($urandom_range(0, 199) == 0);
        @(negedge clk);
      end
      stall = 1'b0; redirect_valid = 1'b0; start = 1'b0; rst = 1'b0;
      @(negedge clk);
    end

    check("sb_drained", exp_q.size(), 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
